// File: rtl/mlp_train_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_train_ctrl
//  Description : Training sequencer for the O/X MLP.
//                It runs epochs over a sample store. For each sample it
//                fetches (x, target) and launches a forward pass. It then
//                forms a saturated error and pulses learn to the update block
//                when the error is outside tolerance. It reports the epoch
//                count, the mistakes per epoch, convergence and a forward
//                timeout fault.
//  Options     : MLP_TRAIN_EARLY_STOP_EN - finish the run after the first
//                epoch that has no mistakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mlp_train_ctrl #(
  parameter int W       = 8,
  parameter int AW      = 6,
  parameter int EW      = 8,
  parameter int ERR_TOL = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   n_samples,
  input  logic [EW-1:0] max_epochs,
  output logic [AW-1:0] samp_addr,
  input  logic [15:0]   samp_x,
  input  logic [W-1:0]  samp_t,
  output logic          fwd_start,
  input  logic          fwd_done,
  input  logic [W-1:0]  fwd_y,
  output logic          learn,
  output logic [15:0]   x,
  output logic [W-1:0]  err,
  output logic          busy,
  output logic          done,
  output logic [EW-1:0] epoch_cnt,
  output logic [AW:0]   miss_cnt,
  output logic          converged,
  output logic          fault
);

  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);
  localparam logic signed [W:0] SAT_HI = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] SAT_LO = {2'b11, {(W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_READ  = 4'd2,
    S_FWD   = 4'd3,
    S_WAIT  = 4'd4,
    S_JUDGE = 4'd5,
    S_NEXT  = 4'd6,
    S_EPOCH = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   n_q, n_d;
  logic [EW-1:0] max_q, max_d;
  logic [15:0]   x_q, x_d;
  logic [W-1:0]  t_q, t_d;
  logic [W-1:0]  err_q, err_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [AW:0]   miss_acc_q, miss_acc_d;
  logic [EW-1:0] epoch_q, epoch_d;
  logic [AW:0]   miss_cnt_q, miss_cnt_d;
  logic          conv_q, conv_d;
  logic          fault_q, fault_d;
  logic          learn_c;

  logic signed [W:0] diff;
  logic [W-1:0]      err_sat;
  logic [W:0]        err_ext;
  logic [W:0]        err_abs;
  logic              is_miss;
  logic              last_sample;
  logic              last_epoch;
  logic              early_stop;
  logic              busy_c;

  // Error arithmetic: a W+1 bit difference clamped to W bits, and its magnitude
  // kept at W+1 bits so that the most negative error is not wrapped.
  always_comb begin
    diff = $signed({t_q[W-1], t_q}) - $signed({fwd_y[W-1], fwd_y});
    if (diff > SAT_HI) begin
      err_sat = {1'b0, {(W-1){1'b1}}};
    end else if (diff < SAT_LO) begin
      err_sat = {1'b1, {(W-1){1'b0}}};
    end else begin
      err_sat = diff[W-1:0];
    end
    err_ext     = {err_q[W-1], err_q};
    err_abs     = err_q[W-1] ? (~err_ext + (W+1)'(1)) : err_ext;
    is_miss     = (err_abs > (W+1)'(ERR_TOL));
    last_sample = ({1'b0, idx_q} == (n_q - (AW+1)'(1)));
    last_epoch  = (({1'b0, epoch_q} + (EW+1)'(1)) == {1'b0, max_q});
    busy_c      = (state_q != S_IDLE) && (state_q != S_DONE);
  end

`ifdef MLP_TRAIN_EARLY_STOP_EN
  assign early_stop = (miss_acc_q == '0);
`else
  assign early_stop = 1'b0;
`endif

  // Sequencer next state and register updates. An abort freezes all
  // bookkeeping, so it also beats fwd_done and suppresses learn.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    max_d      = max_q;
    x_d        = x_q;
    t_d        = t_q;
    err_d      = err_q;
    wdog_d     = wdog_q;
    miss_acc_d = miss_acc_q;
    epoch_d    = epoch_q;
    miss_cnt_d = miss_cnt_q;
    conv_d     = conv_q;
    fault_d    = fault_q;
    learn_c    = 1'b0;

    if (abort && busy_c) begin
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_d        = n_samples;
            max_d      = max_epochs;
            idx_d      = '0;
            miss_acc_d = '0;
            epoch_d    = '0;
            miss_cnt_d = '0;
            conv_d     = 1'b0;
            fault_d    = 1'b0;
            state_d    = ((n_samples != '0) && (max_epochs != '0)) ? S_FETCH : S_DONE;
          end
        end
        S_FETCH: state_d = S_READ;
        S_READ: begin
          x_d     = samp_x;
          t_d     = samp_t;
          state_d = S_FWD;
        end
        S_FWD: begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (fwd_done) begin
            err_d   = err_sat;
            state_d = S_JUDGE;
          end else if (wdog_q == WDOG_LAST) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else begin
            wdog_d = wdog_q + WDW'(1);
          end
        end
        S_JUDGE: begin
          if (is_miss) begin
            miss_acc_d = miss_acc_q + (AW+1)'(1);
            learn_c    = 1'b1;
          end
          state_d = S_NEXT;
        end
        S_NEXT: begin
          if (last_sample) begin
            state_d = S_EPOCH;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_FETCH;
          end
        end
        S_EPOCH: begin
          if (epoch_q != {EW{1'b1}}) begin
            epoch_d = epoch_q + EW'(1);
          end
          miss_cnt_d = miss_acc_q;
          conv_d     = (miss_acc_q == '0);
          miss_acc_d = '0;
          idx_d      = '0;
          state_d    = (last_epoch || early_stop) ? S_DONE : S_FETCH;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      max_q      <= '0;
      x_q        <= '0;
      t_q        <= '0;
      err_q      <= '0;
      wdog_q     <= '0;
      miss_acc_q <= '0;
      epoch_q    <= '0;
      miss_cnt_q <= '0;
      conv_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      max_q      <= max_d;
      x_q        <= x_d;
      t_q        <= t_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
      miss_acc_q <= miss_acc_d;
      epoch_q    <= epoch_d;
      miss_cnt_q <= miss_cnt_d;
      conv_q     <= conv_d;
      fault_q    <= fault_d;
    end
  end

  // Pulses are masked while reset is asserted so that a mid-run reset emits none.
  assign fwd_start = (state_q == S_FWD) && !rst;
  assign done      = (state_q == S_DONE) && !rst;
  assign learn     = learn_c && !rst;
  assign busy      = busy_c;
  assign samp_addr = idx_q;
  assign x         = x_q;
  assign err       = err_q;
  assign epoch_cnt = epoch_q;
  assign miss_cnt  = miss_cnt_q;
  assign converged = conv_q;
  assign fault     = fault_q;

endmodule
`default_nettype wire
